// File: rtl/sfp_pkg.sv
// Shared constants and FSM encoding for the psum accumulation sequencer.
package sfp_pkg;
  localparam int COL         = 8;
  localparam int PSUM_BW     = 16;
  localparam int NUM_KIJ     = 9;
  localparam int NUM_PIX     = 16;
  localparam int TOTAL_READS = NUM_KIJ * NUM_PIX;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;
endpackage

// File: rtl/psum_addr_gen.sv
// Pixel-outer / kij-inner read counters and psum SRAM address generation.
module psum_addr_gen
  import sfp_pkg::*;
#(
  parameter int num_kij     = NUM_KIJ,
  parameter int num_pix     = NUM_PIX,
  parameter int addr_bw     = 11,
  parameter int out_addr_bw = 4,
  localparam int KW = (num_kij > 1) ? $clog2(num_kij) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   step,
  output logic [out_addr_bw-1:0] o,
  output logic [addr_bw-1:0]     addr,
  output logic                   k_first,
  output logic                   k_last,
  output logic                   tile_last
);
  logic [KW-1:0] k;
  logic          o_last;

  assign k_first   = (k == '0);
  assign k_last    = (k == KW'(num_kij - 1));
  assign o_last    = (o == out_addr_bw'(num_pix - 1));
  assign tile_last = k_last && o_last;

  // Operands widened to the full address width before the multiply.
  assign addr = addr_bw'(k) * addr_bw'(num_pix) + addr_bw'(o);

  // o wraps explicitly so the address idles at 0 between tiles.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      k <= '0;
      o <= '0;
    end else if (step) begin
      if (k_last) begin
        k <= '0;
        o <= o_last ? '0 : o + 1'b1;
      end else begin
        k <= k + 1'b1;
      end
    end
  end
endmodule

// File: rtl/psum_acc_ctrl.sv
// Streams psum SRAM vectors through the SFP and writes final per-pixel sums.
module psum_acc_ctrl
  import sfp_pkg::*;
#(
  parameter int col         = COL,
  parameter int psum_bw     = PSUM_BW,
  parameter int num_kij     = NUM_KIJ,
  parameter int num_pix     = NUM_PIX,
  parameter int addr_bw     = 11,
  parameter int out_addr_bw = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       relu_mode,
  output logic                       busy,
  output logic                       done,
  output logic                       psum_cen,
  output logic [addr_bw-1:0]         psum_addr,
  input  logic [psum_bw*col-1:0]     psum_q,
  output logic [psum_bw*col-1:0]     sfp_in,
  output logic                       sfp_acc_en,
  output logic                       sfp_relu_en,
  output logic                       sfp_valid_in,
  input  logic [psum_bw*col-1:0]     sfp_out,
  input  logic                       sfp_valid_out,
  output logic                       out_cen,
  output logic                       out_wen,
  output logic [out_addr_bw-1:0]     out_addr,
  output logic [psum_bw*col-1:0]     out_d
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic                   first;
    logic                   last;
    logic [out_addr_bw-1:0] o;
  } tag_t;

  state_t                 state;
  logic                   drain_cnt;
  logic                   relu_lat;
  logic                   run, accept, wr;
  logic                   k_first, k_last, tile_last;
  logic [out_addr_bw-1:0] o;
  logic [STAGES:1]        vld_q;
  logic [STAGES:0]        vld_pipe;
  tag_t                   tag_in, s1_tag;
  logic                   s2_last;
  logic [out_addr_bw-1:0] s2_o;

  assign accept = (state == IDLE) && start;
  assign run    = (state == RUN);

  psum_addr_gen #(
    .num_kij(num_kij), .num_pix(num_pix),
    .addr_bw(addr_bw), .out_addr_bw(out_addr_bw)
  ) u_addr_gen (
    .clk(clk), .reset(reset), .clear(accept), .step(run),
    .o(o), .addr(psum_addr),
    .k_first(k_first), .k_last(k_last), .tile_last(tile_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
      relu_lat  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= RUN;
          relu_lat <= relu_mode;
        end
        RUN: if (tile_last) begin
          state     <= DRAIN;
          drain_cnt <= 1'b0;
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1 lines up with psum_q, stage 2 with sfp_valid_out.
  assign tag_in   = '{first: k_first, last: k_last, o: o};
  assign vld_pipe = {vld_q, run};

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q   <= '0;
      s1_tag  <= '0;
      s2_last <= 1'b0;
      s2_o    <= '0;
    end else begin
      vld_q   <= vld_pipe[STAGES-1:0];
      s1_tag  <= tag_in;
      s2_last <= s1_tag.last;
      s2_o    <= s1_tag.o;
    end
  end

  assign psum_cen     = !run;
  assign sfp_in       = psum_q;
  assign sfp_valid_in = vld_pipe[1];
  assign sfp_acc_en   = vld_pipe[1] && !s1_tag.first;
  assign sfp_relu_en  = vld_pipe[1] && s1_tag.last && relu_lat;

  assign wr       = sfp_valid_out && vld_pipe[STAGES] && s2_last;
  assign out_cen  = !wr;
  assign out_wen  = !wr;
  assign out_addr = s2_o;
  assign out_d    = sfp_out;

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Scoreboard bench: SRAM + SFP behavioural models, expected writes/reads queued per tile.
module tb_psum_acc_ctrl;
  import sfp_pkg::*;
  localparam int C = COL, BW = PSUM_BW, NK = NUM_KIJ, NP = NUM_PIX, NR = TOTAL_READS;
  localparam int AW = 11, OAW = 4, DW = C * BW;

  typedef struct { int addr; int rel; logic [DW-1:0] d; } wr_t;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, relu_mode = 1'b0;
  logic busy, done, psum_cen, sfp_acc_en, sfp_relu_en, sfp_valid_in, sfp_valid_out;
  logic out_cen, out_wen;
  logic [AW-1:0]  psum_addr;
  logic [OAW-1:0] out_addr;
  logic [DW-1:0]  psum_q, sfp_in, sfp_out, out_d, acc;

  logic start_s = 1'b0;
  logic busy_s, done_s, psum_cen_s, sfp_acc_en_s, sfp_relu_en_s, sfp_valid_in_s, sfp_valid_out_s;
  logic out_cen_s, out_wen_s;
  logic [1:0]    psum_addr_s, out_addr_s;
  logic [DW-1:0] psum_q_s, sfp_in_s, sfp_out_s, out_d_s, acc_s;

  int cyc = 0, t0 = 0, n_chk = 0, n_pass = 0, n_fail = 0;
  bit tile_on = 1'b0;
  logic [DW-1:0] mem [NR];
  logic [DW-1:0] mem_s [4];
  wr_t  exp_wr[$], exp_s[$], mw, sw;
  int   exp_rd[$];
  logic [1:0] exp_ctl[$];

  psum_acc_ctrl #(.col(C), .psum_bw(BW), .num_kij(NK), .num_pix(NP),
                  .addr_bw(AW), .out_addr_bw(OAW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .relu_mode(relu_mode),
    .busy(busy), .done(done), .psum_cen(psum_cen), .psum_addr(psum_addr),
    .psum_q(psum_q), .sfp_in(sfp_in), .sfp_acc_en(sfp_acc_en),
    .sfp_relu_en(sfp_relu_en), .sfp_valid_in(sfp_valid_in), .sfp_out(sfp_out),
    .sfp_valid_out(sfp_valid_out), .out_cen(out_cen), .out_wen(out_wen),
    .out_addr(out_addr), .out_d(out_d));

  psum_acc_ctrl #(.col(C), .psum_bw(BW), .num_kij(1), .num_pix(4),
                  .addr_bw(2), .out_addr_bw(2)) u_small (
    .clk(clk), .reset(reset), .start(start_s), .relu_mode(1'b1),
    .busy(busy_s), .done(done_s), .psum_cen(psum_cen_s), .psum_addr(psum_addr_s),
    .psum_q(psum_q_s), .sfp_in(sfp_in_s), .sfp_acc_en(sfp_acc_en_s),
    .sfp_relu_en(sfp_relu_en_s), .sfp_valid_in(sfp_valid_in_s), .sfp_out(sfp_out_s),
    .sfp_valid_out(sfp_valid_out_s), .out_cen(out_cen_s), .out_wen(out_wen_s),
    .out_addr(out_addr_s), .out_d(out_d_s));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rep(input logic [BW-1:0] v);
    return {C{v}};
  endfunction

  // SFP behaviour: per-column wrap-around accumulate, ReLU on the output only.
  function automatic logic [DW-1:0] accum(input logic [DW-1:0] a, input logic [DW-1:0] x, input logic en);
    logic [DW-1:0] r;
    for (int c = 0; c < C; c++) r[c*BW +: BW] = (en ? a[c*BW +: BW] : '0) + x[c*BW +: BW];
    return r;
  endfunction

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] a, input logic en);
    logic [DW-1:0] r;
    for (int c = 0; c < C; c++) r[c*BW +: BW] = (en && a[c*BW+BW-1]) ? '0 : a[c*BW +: BW];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!psum_cen) psum_q <= mem[psum_addr];
    if (!psum_cen_s) psum_q_s <= mem_s[psum_addr_s];
    if (!reset) begin
      sfp_valid_out <= 1'b0; acc <= '0;
      sfp_valid_out_s <= 1'b0; acc_s <= '0;
    end else begin
      sfp_valid_out <= sfp_valid_in;
      if (sfp_valid_in) begin
        acc     <= accum(acc, sfp_in, sfp_acc_en);
        sfp_out <= relu(accum(acc, sfp_in, sfp_acc_en), sfp_relu_en);
      end
      sfp_valid_out_s <= sfp_valid_in_s;
      if (sfp_valid_in_s) begin
        acc_s     <= accum(acc_s, sfp_in_s, sfp_acc_en_s);
        sfp_out_s <= relu(accum(acc_s, sfp_in_s, sfp_acc_en_s), sfp_relu_en_s);
      end
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bad(input string nm);
    n_chk++; n_fail++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string nm);
    chk(nm, {psum_cen, psum_addr, sfp_valid_in, sfp_acc_en, sfp_relu_en,
             out_cen, out_wen, out_addr, busy, done},
            {1'b1, {AW{1'b0}}, 3'b000, 2'b11, {OAW{1'b0}}, 2'b00});
  endtask

  // Reference: out[o] = sum over kij of psum[k*NP+o], wrapped to BW bits, optional ReLU.
  task automatic plan_tile(input int kind, input bit rl);
    for (int a = 0; a < NR; a++)
      for (int c = 0; c < C; c++)
        case (kind)
          0:       mem[a][c*BW +: BW] = BW'(1);
          1:       mem[a][c*BW +: BW] = BW'(-2);
          2:       mem[a][c*BW +: BW] = BW'(a);
          default: mem[a][c*BW +: BW] = BW'($urandom);
        endcase
    for (int o = 0; o < NP; o++) begin
      wr_t w;
      w.addr = o;
      w.rel  = NK * (o + 1) + 2;
      for (int c = 0; c < C; c++) begin
        int s;
        logic [BW-1:0] t;
        s = 0;
        for (int k = 0; k < NK; k++) s += int'($signed(mem[k*NP+o][c*BW +: BW]));
        t = BW'(s);
        if (rl && t[BW-1]) t = '0;
        w.d[c*BW +: BW] = t;
      end
      exp_wr.push_back(w);
      for (int k = 0; k < NK; k++) begin
        exp_rd.push_back(k * NP + o);
        exp_ctl.push_back({k != 0, rl && (k == NK - 1)});
      end
    end
  endtask

  task automatic run_tile(input int kind, input bit rl, input int abort_at, input bit chain);
    plan_tile(kind, rl);
    relu_mode = rl; start = 1'b1;
    t0 = cyc; tile_on = 1'b1;
    for (int r = 0; r < (chain ? NR + 4 : NR + 7); r++) begin
      if (r == 50 || r == NR + 3) start = 1'b1;
      if (r == abort_at) begin
        tile_on = 1'b0; start = 1'b0; reset = 1'b0;
        exp_wr.delete(); exp_rd.delete(); exp_ctl.delete();
        tick(); chk_reset("reset_mid_tile");
        tick(); reset = 1'b1;
        repeat (20) tick();
        return;
      end
      tick(); start = 1'b0;
      relu_mode = 1'($urandom_range(0, 1));
    end
    tile_on = 1'b0;
    chk("writes_outstanding", exp_wr.size(), 0);
    chk("reads_outstanding", exp_rd.size(), 0);
  endtask

  always @(negedge clk) if (reset) begin
    if (tile_on) begin
      chk("psum_cen", psum_cen, !(cyc - t0 >= 1 && cyc - t0 <= NR));
      chk("busy", busy, cyc - t0 >= 1 && cyc - t0 <= NR + 2);
      chk("done", done, cyc - t0 == NR + 3);
    end
    if (!psum_cen) begin
      if (exp_rd.size() == 0) bad("spurious_read");
      else chk("rd_addr", psum_addr, exp_rd.pop_front());
    end
    if (sfp_valid_in) begin
      if (exp_ctl.size() == 0) bad("spurious_sfp_valid");
      else chk("sfp_ctl_acc_relu", {sfp_acc_en, sfp_relu_en}, exp_ctl.pop_front());
    end
    if (!out_cen && !out_wen) begin
      if (exp_wr.size() == 0) bad("spurious_write");
      else begin
        mw = exp_wr.pop_front();
        chk("wr_addr", out_addr, mw.addr);
        chk("wr_data", out_d, mw.d);
        chk("wr_cycle", cyc - t0, mw.rel);
      end
    end
    if (!out_cen_s && !out_wen_s) begin
      if (exp_s.size() == 0) bad("small_spurious_write");
      else begin
        sw = exp_s.pop_front();
        chk("small_wr_addr", out_addr_s, sw.addr);
        chk("small_wr_data", out_d_s, sw.d);
      end
    end
    if (sfp_valid_in_s) chk("small_ctl_acc_relu", {sfp_acc_en_s, sfp_relu_en_s}, 2'b01);
  end

  initial begin
    int ts;
    wr_t w;
    mem_s[0] = rep(BW'(-3)); mem_s[1] = rep(BW'(5));
    mem_s[2] = rep(BW'(0));  mem_s[3] = rep(BW'(-1));
    repeat (3) tick();
    chk_reset("reset_values");
    reset = 1'b1;
    tick();

    run_tile(0, 1'b0, -1, 1'b0);
    run_tile(1, 1'b0, -1, 1'b1);
    run_tile(1, 1'b1, -1, 1'b0);
    run_tile(2, 1'b0, -1, 1'b0);
    run_tile(3, 1'b1, 60, 1'b0);
    run_tile(3, 1'($urandom_range(0, 1)), -1, 1'b0);
    run_tile(3, 1'($urandom_range(0, 1)), -1, 1'b0);

    for (int o = 0; o < 4; o++) begin
      w.addr = o; w.rel = 0;
      w.d = (o == 1) ? rep(BW'(5)) : '0;
      exp_s.push_back(w);
    end
    start_s = 1'b1; ts = cyc;
    tick(); start_s = 1'b0;
    for (int r = 1; r <= 9; r++) begin
      chk("small_busy", busy_s, cyc - ts <= 6);
      chk("small_done", done_s, cyc - ts == 7);
      tick();
    end
    chk("small_writes_outstanding", exp_s.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
